pipeline_wr_en_ctrl: RTL
========================

// Module: pipeline_wr_en_ctrl
// PURPOSE
//  Hazard controller driving the wr_en/flush inputs of the 5-stage pipeline registers (PC, IF/ID, ID/EX,
//  EX/MEM, MEM/WB). Detects load-use hazards, holds the pipeline for fixed-latency multicycle EX ops
//  (mul/div), and squashes wrong-path instructions on a taken branch/jump resolved in EX.
//  All pipeline registers are async-reset DFFs with wr_en; this block is the sole source of those enables.
// PARAMETERS
//  MC_LATENCY  4   stall cycles per multicycle EX op; legal range 2..255
//  CNT_W       8   width of the multicycle down-counter; must satisfy 2**CNT_W > MC_LATENCY
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-low
//  id_rs1         in   5   rs1 index of the instruction in ID
//  id_rs2         in   5   rs2 index of the instruction in ID
//  id_uses_rs1    in   1   instruction in ID reads rs1
//  id_uses_rs2    in   1   instruction in ID reads rs2
//  ex_rd          in   5   rd index of the instruction in EX
//  ex_is_load     in   1   instruction in EX is a load
//  ex_mc_start    in   1   instruction in EX is a multicycle op (level, decoded from EX)
//  ex_branch_taken in  1   taken branch/jump resolved in EX
//  pc_wr_en, ifid_wr_en, idex_wr_en, exmem_wr_en, memwb_wr_en   out 1 each   register write enables
//  ifid_flush, idex_flush, exmem_flush                          out 1 each   load bubble (NOP) instead of d
//  mc_busy        out  1   multicycle op is stalling EX this cycle
// BEHAVIOUR
//  - FSM states RUN, MC_BUSY, MC_DONE; down-counter cnt[CNT_W-1:0]. All outputs are combinational from state + inputs.
//  - Reset (rst low, async): state=RUN, cnt=0. While rst is low: every wr_en=0, every flush=0, mc_busy=0.
//    Deasserting reset mid-multicycle restarts in RUN; an op in EX with ex_mc_start=1 restarts its full latency.
//  - Default (no hazard): every wr_en=1, every flush=0, mc_busy=0.
//  - Priority, highest first: multicycle stall > branch flush > load-use stall.
//  - Multicycle op:
//    - RUN & ex_mc_start: stall, then next=MC_BUSY, cnt<=MC_LATENCY-2.
//    - MC_BUSY: stall; if cnt==0, next=MC_DONE, else cnt<=cnt-1.
//    - MC_DONE: default outputs (result advances to MEM); next=RUN; ex_mc_start is ignored in this state.
//    - Stall outputs: pc/ifid/idex/exmem_wr_en=0, memwb_wr_en=1, exmem_flush=1 (bubble into MEM), mc_busy=1.
//    - Net effect: exactly MC_LATENCY stall cycles, followed by one advance cycle (EX occupancy MC_LATENCY+1).
//    - ex_branch_taken and load-use are ignored while stalling.
//  - Branch (RUN or MC_DONE, ex_branch_taken=1): ifid_flush=1, idex_flush=1, all wr_en=1 (PC loads target).
//    This overrides a simultaneous load-use hazard, because the ID instruction is wrong-path.
//  - Load-use hazard:
//    - Condition: ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//    - Response: pc_wr_en=0, ifid_wr_en=0, idex_flush=1; other enables 1. Lasts exactly 1 cycle, because the load leaves EX.
//    - A load with ex_rd=0 never stalls.
//  - ex_mc_start and ex_is_load asserted together is illegal; the multicycle path wins (assertion in sim).
// CONFIGURATION
//  STALL_STATS_EN defined:
//    - Adds outputs stall_cycles[31:0] and flush_events[31:0]. Both reset to 0 and saturate at 32'hFFFF_FFFF.
//    - stall_cycles increments on every cycle with pc_wr_en==0 and rst high.
//    - flush_events increments on every cycle where a branch flush is applied.
//  STALL_STATS_EN undefined: the ports exist, are tied to 0, and no counter flops are instantiated.
// TESTING
//  1 ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle of pc_wr_en=0, ifid_wr_en=0, idex_flush=1, then defaults
//  2 same as 1 but ex_rd=0, or id_uses_rs1=0 -> no stall, all wr_en=1
//  3 MC_LATENCY=4, ex_mc_start held 1 -> mc_busy=1 and exmem_flush=1 for 4 cycles, 5th cycle all wr_en=1, state RUN
//  4 ex_branch_taken=1 with a load-use match in the same cycle -> ifid_flush=idex_flush=1, pc_wr_en=1, no stall
//  5 rst pulsed low in 2nd MC_BUSY cycle -> outputs all 0 immediately; after release, RUN and defaults
//  6 STALL_STATS_EN, run scenarios 1+3+4 -> stall_cycles=5, flush_events=1

Source files
------------

// File: rtl/pipeline_wr_en_ctrl.sv
// Purpose: hazard controller producing wr_en/flush for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Latency: outputs are combinational from FSM state and current inputs (0 cycles); multicycle EX ops stall MC_LATENCY cycles.
// Backpressure: stalls hold upstream registers (wr_en=0) and inject bubbles downstream via flush; no handshake.
// Optional feature macro: STALL_STATS_EN adds live stall_cycles/flush_events counters (ports tied to 0 otherwise).
// MC_LATENCY legal range is 2..255; CNT_W must satisfy 2**CNT_W > MC_LATENCY.

module pipeline_wr_en_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_mc_start,
    input  logic        ex_branch_taken,
    output logic        pc_wr_en,
    output logic        ifid_wr_en,
    output logic        idex_wr_en,
    output logic        exmem_wr_en,
    output logic        memwb_wr_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        mc_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } state_t;

    // The RUN cycle that accepts the op is itself a stall, so the counter
    // only has to cover the remaining MC_LATENCY-1 cycles (cnt runs N-2 .. 0).
    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             load_use;
    logic             mc_stall;
    logic             branch_flush;

    // State register and multicycle down-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: MC_DONE always returns to RUN so a back-to-back
    // multicycle op is only accepted after the previous result has advanced.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (ex_mc_start) begin
                    state_nxt = MC_BUSY;
                    cnt_nxt   = MC_LOAD;
                end
            end
            MC_BUSY: begin
                if (cnt == '0) begin
                    state_nxt = MC_DONE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            MC_DONE: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Hazard decode: a load writing x0 can never create a dependency.
    always_comb begin
        load_use     = ex_is_load && (ex_rd != 5'd0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));
        mc_stall     = ((state == RUN) && ex_mc_start) || (state == MC_BUSY);
        branch_flush = rst && !mc_stall && ex_branch_taken;
    end

    // Output logic, priority: reset > multicycle stall > branch flush > load-use.
    always_comb begin
        pc_wr_en    = 1'b1;
        ifid_wr_en  = 1'b1;
        idex_wr_en  = 1'b1;
        exmem_wr_en = 1'b1;
        memwb_wr_en = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mc_busy     = 1'b0;
        if (!rst) begin
            pc_wr_en    = 1'b0;
            ifid_wr_en  = 1'b0;
            idex_wr_en  = 1'b0;
            exmem_wr_en = 1'b0;
            memwb_wr_en = 1'b0;
        end else if (mc_stall) begin
            // Freeze everything up to EX; MEM receives a bubble while WB drains.
            pc_wr_en    = 1'b0;
            ifid_wr_en  = 1'b0;
            idex_wr_en  = 1'b0;
            exmem_wr_en = 1'b0;
            exmem_flush = 1'b1;
            mc_busy     = 1'b1;
        end else if (branch_flush) begin
            // The ID instruction is wrong-path, so a coincident load-use is moot.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (load_use) begin
            pc_wr_en    = 1'b0;
            ifid_wr_en  = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    // Decode guarantees a single instruction cannot be both load and multicycle.
    a_no_load_and_mc: assert property (@(posedge clk) disable iff (!rst)
        !(ex_mc_start && ex_is_load));

`ifdef STALL_STATS_EN
    // Saturating counters of stalled cycles and applied branch flushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_wr_en && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_flush && (flush_events != 32'hFFFF_FFFF)) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
